// File: rtl/c17_pattern_gen.sv
// c17_pattern_gen: exhaustive-sweep or LFSR vector source for c17 with settle window and valid/ready offer
// ports: clk/rst; start/mode/abort run control; ready from the capture stage;
//        N1,N2,N3,N6,N7 = vec[0..4]; vec_valid/vec_idx offer the settled vector; busy/done report run status
module c17_pattern_gen #(
  parameter int         HOLD_CYCLES = 2,
  parameter logic [4:0] LFSR_SEED   = 5'b00001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic       ready,
  output logic       N1,
  output logic       N2,
  output logic       N3,
  output logic       N6,
  output logic       N7,
  output logic       vec_valid,
  output logic [4:0] vec_idx,
  output logic       busy,
  output logic       done
);
  // counter keeps at least one bit so a zero settle window still elaborates
  localparam int              SW    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [SW-1:0]   SLAST = SW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [4:0]      SEED  = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
  localparam logic [1:0]      IDLE = 2'd0, SETTLE = 2'd1, VALID = 2'd2, DONE = 2'd3;
  localparam logic [1:0]      FIRST = (HOLD_CYCLES == 0) ? VALID : SETTLE;
  logic [1:0]    state_q, state_d;
  logic [4:0]    vec_q, vec_d, idx_q, idx_d, nxt;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          mode_q, mode_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic          launch, active, hs, last;
  always_comb begin
    launch  = start & ((state_q == IDLE) | (state_q == DONE));
    active  = (state_q == SETTLE) | (state_q == VALID);
    // abort beats a coincident handshake, so the vector is not consumed
    hs      = (state_q == VALID) & ready & ~abort;
    last    = idx_q == (mode_q ? 5'd30 : 5'd31);
    nxt     = mode_q ? {vec_q[3:0], vec_q[4] ^ vec_q[2]} : vec_q + 5'd1;
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    mode_d  = mode_q;
    if (launch) begin
      mode_d  = mode;
      idx_d   = 5'd0;
      vec_d   = mode ? SEED : 5'd0;
      scnt_d  = '0;
      state_d = FIRST;
    end else if (active & abort) begin
      state_d = IDLE;
    end else if (state_q == SETTLE) begin
      state_d = (scnt_q == SLAST) ? VALID : SETTLE;
      scnt_d  = scnt_q + 1'b1;
    end else if (hs) begin
      state_d = last ? DONE : FIRST;
      vec_d   = last ? vec_q : nxt;
      idx_d   = last ? idx_q : idx_q + 5'd1;
      scnt_d  = '0;
    end
    valid_d = state_d == VALID;
    busy_d  = (state_d == SETTLE) | (state_d == VALID);
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      scnt_q  <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign {N7, N6, N3, N2, N1} = vec_q;
  assign vec_valid = valid_q;
  assign vec_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_c17_pattern_gen.sv
// tb_c17_pattern_gen: table, directed and randomized checks of c17_pattern_gen
module tb_c17_pattern_gen;
  localparam logic L = 1'b0, H = 1'b1;
  logic clk = 1'b0;
  logic rst, start, mode, abort, ready;
  logic n1, n2, n3, n6, n7, vec_valid, busy, done;
  logic [4:0] vec_idx, nv;
  logic b_start, b_mode, b_abort, b_ready;
  logic b1, b2, b3, b6, b7, b_valid, b_busy, b_done;
  logic [4:0] b_idx, bv;
  int checks = 0, failures = 0;

  c17_pattern_gen #(.HOLD_CYCLES(2), .LFSR_SEED(5'b00001)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .ready(ready),
    .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7),
    .vec_valid(vec_valid), .vec_idx(vec_idx), .busy(busy), .done(done));

  c17_pattern_gen #(.HOLD_CYCLES(0), .LFSR_SEED(5'b00000)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .abort(b_abort), .ready(b_ready),
    .N1(b1), .N2(b2), .N3(b3), .N6(b6), .N7(b7),
    .vec_valid(b_valid), .vec_idx(b_idx), .busy(b_busy), .done(b_done));

  assign nv = {n7, n6, n3, n2, n1};
  assign bv = {b7, b6, b3, b2, b1};

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, m, a, rd;
    logic [4:0] v, i;
    logic val, b, d;
  } row_t;
  row_t tbl[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // expected run contents derived from the counting / shift-register rules
  function automatic void seq(input logic m, output logic [4:0] e[32]);
    logic [4:0] v;
    v = m ? 5'd1 : 5'd0;
    for (int i = 0; i < 32; i++) begin
      e[i] = v;
      v = m ? {v[3:0], v[4] ^ v[2]} : v + 5'd1;
    end
  endfunction

  // one full run: vector order, index, settle timing and completion
  task automatic run(input logic m, input bit rnd);
    logic [4:0] e[32];
    int len, k, since, cyc;
    bit ev, hs;
    seq(m, e);
    len = m ? 31 : 32;
    k = 0; since = 0; cyc = 0;
    mode = m; start = 1'b1;
    tick;
    start = 1'b0;
    while (k < len && cyc < 4000) begin
      ev = since >= 2;
      chk($sformatf("run%0d vec k=%0d", m, k), nv, e[k]);
      chk($sformatf("run%0d idx", m), vec_idx, k);
      chk($sformatf("run%0d valid k=%0d since=%0d", m, k, since), vec_valid, ev);
      chk($sformatf("run%0d busy", m), busy, 1);
      chk($sformatf("run%0d done", m), done, 0);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mode  = 1'($urandom);
      start = rnd && ($urandom_range(0, 7) == 0);
      hs = ev && ready;
      tick;
      cyc++;
      if (hs) begin k++; since = 0; end else since++;
    end
    start = 1'b0; ready = 1'b0;
    chk($sformatf("run%0d handshakes", m), k, len);
    chk($sformatf("run%0d end done", m), done, 1);
    chk($sformatf("run%0d end busy", m), busy, 0);
    chk($sformatf("run%0d end valid", m), vec_valid, 0);
    chk($sformatf("run%0d end vec", m), nv, e[len-1]);
  endtask

  task automatic advance_to(input int idx, input logic want_valid);
    int cyc;
    cyc = 0;
    while (!(vec_idx == 5'(idx) && vec_valid == want_valid) && cyc < 500) begin
      ready = 1'b1;
      tick;
      cyc++;
    end
    ready = 1'b0;
    chk("advance idx", vec_idx, idx);
    chk("advance valid", vec_valid, want_valid);
  endtask

  initial begin
    logic [4:0] e[32];
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; ready = 1'b0;
    b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    //            r  s  m  a  rd    vec    idx    val b  d
    tbl[0]  = '{H, L, L, L, L, 5'd0, 5'd0, L, L, L};
    tbl[1]  = '{H, H, L, L, L, 5'd0, 5'd0, L, L, L};
    tbl[2]  = '{L, L, L, L, L, 5'd0, 5'd0, L, L, L};
    tbl[3]  = '{L, H, L, L, L, 5'd0, 5'd0, L, H, L};
    tbl[4]  = '{L, L, L, L, L, 5'd0, 5'd0, L, H, L};
    tbl[5]  = '{L, L, L, L, L, 5'd0, 5'd0, H, H, L};
    tbl[6]  = '{L, L, L, L, H, 5'd1, 5'd1, L, H, L};
    tbl[7]  = '{L, L, L, L, H, 5'd1, 5'd1, L, H, L};
    tbl[8]  = '{L, L, L, L, H, 5'd1, 5'd1, H, H, L};
    tbl[9]  = '{L, L, L, H, H, 5'd1, 5'd1, L, L, L};
    tbl[10] = '{L, L, L, H, L, 5'd1, 5'd1, L, L, L};
    tbl[11] = '{L, H, H, L, L, 5'd1, 5'd0, L, H, L};
    tbl[12] = '{L, L, L, L, L, 5'd1, 5'd0, L, H, L};
    tbl[13] = '{L, L, L, L, L, 5'd1, 5'd0, H, H, L};
    tbl[14] = '{L, H, L, L, H, 5'd2, 5'd1, L, H, L};
    tbl[15] = '{H, L, L, L, L, 5'd0, 5'd0, L, L, L};
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r; start = tbl[i].s; mode = tbl[i].m; abort = tbl[i].a; ready = tbl[i].rd;
      tick;
      chk($sformatf("tbl[%0d] vec", i), nv, tbl[i].v);
      chk($sformatf("tbl[%0d] idx", i), vec_idx, tbl[i].i);
      chk($sformatf("tbl[%0d] valid", i), vec_valid, tbl[i].val);
      chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].b);
      chk($sformatf("tbl[%0d] done", i), done, tbl[i].d);
    end
    rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; ready = 1'b0;
    tick;

    run(1'b0, 1'b0);
    run(1'b1, 1'b0);
    run(1'b0, 1'b1);
    run(1'b1, 1'b1);
    run(1'b1, 1'b1);

    // backpressure on vector 7
    mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    advance_to(7, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp vec", nv, 5'd7);
      chk("bp idx", vec_idx, 7);
      chk("bp valid", vec_valid, 1);
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    chk("bp next vec", nv, 5'd8);
    chk("bp next idx", vec_idx, 8);
    chk("bp next valid", vec_valid, 0);

    // start while busy is ignored, then abort in SETTLE of vector 12
    start = 1'b1; mode = 1'b1;
    tick;
    start = 1'b0;
    chk("busy start idx", vec_idx, 8);
    chk("busy start vec", nv, 5'd8);
    advance_to(12, 1'b0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort valid", vec_valid, 0);
    chk("abort done", done, 0);
    chk("abort vec", nv, 5'd12);
    tick;
    chk("abort stays idle", busy, 0);
    mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart vec", nv, 5'd0);
    chk("restart idx", vec_idx, 0);
    chk("restart busy", busy, 1);

    // reset in VALID at vector 20
    advance_to(20, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst vec", nv, 5'd0);
    chk("rst idx", vec_idx, 0);
    chk("rst valid", vec_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);

    // zero settle window, zero seed replaced by 00001
    seq(1'b1, e);
    b_mode = 1'b1; b_ready = 1'b1; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int k = 0; k < 31; k++) begin
      chk($sformatf("h0 vec k=%0d", k), bv, e[k]);
      chk("h0 idx", b_idx, k);
      chk("h0 valid", b_valid, 1);
      tick;
    end
    chk("h0 done", b_done, 1);
    chk("h0 end valid", b_valid, 0);
    chk("h0 end busy", b_busy, 0);
    chk("h0 end vec", bv, e[30]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c17_pattern_gen.md
Name: c17_pattern_gen

Overview:
Upstream stimulus stage for the c17 combinational benchmark. It drives N1, N2, N3, N6 and N7 with either an exhaustive 32-vector binary sweep or a 31-vector maximal-length LFSR sequence. Each vector is held for a settle window, then offered to the downstream capture/compare stage through a valid/ready handshake. It replaces hand-written vector lists in benches and in the on-chip BIST wrapper.

Parameters:
HOLD_CYCLES, 2, settle cycles between a vector appearing on the N pins and vec_valid asserting (0 allowed)
LFSR_SEED, 5'b00001, initial LFSR state in mode 1; a value of 0 is replaced by 5'b00001

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE or DONE
mode  input  1  0 = exhaustive binary sweep, 1 = LFSR; latched on accepted start
abort  input  1  terminate the run; sampled in SETTLE and VALID
ready  input  1  downstream accepts the current vector
N1  output  1  c17 input, vector bit 0
N2  output  1  c17 input, vector bit 1
N3  output  1  c17 input, vector bit 2
N6  output  1  c17 input, vector bit 3
N7  output  1  c17 input, vector bit 4
vec_valid  output  1  current vector is settled and offered
vec_idx  output  5  index of the current vector within the run
busy  output  1  high in SETTLE and VALID
done  output  1  high in DONE

Behaviour:
- Vector register vec[4:0] maps to {N7,N6,N3,N2,N1}. All outputs are registered.
- Reset: state IDLE; vec=0, so all N pins are 0; vec_valid=0; vec_idx=0; busy=0; done=0. rst has priority over all other inputs in every state.
- FSM states: IDLE, SETTLE, VALID, DONE. A settle counter scnt has width clog2(HOLD_CYCLES+1).
- IDLE or DONE with start=1:
  - latch mode; vec_idx=0; vec=0 if mode=0, else the effective seed; scnt=0.
  - Next state is SETTLE, or VALID directly if HOLD_CYCLES=0.
  - The new vector is visible on the N pins the cycle after start.
- SETTLE:
  - increment scnt each cycle; enter VALID when scnt reaches HOLD_CYCLES-1.
  - vec_valid therefore rises exactly HOLD_CYCLES cycles after the vector first appears.
- VALID:
  - vec_valid=1. vec, the N pins and vec_idx stay stable until a handshake (vec_valid & ready at a rising edge).
  - On handshake, if the vector was the last one: go to DONE with vec_valid=0.
  - On handshake otherwise: advance vec, increment vec_idx, clear scnt, go to SETTLE (or stay in VALID with the new vector if HOLD_CYCLES=0).
- Advance rules:
  - mode 0: vec=vec+1.
  - mode 1 (Fibonacci, x^5+x^3+1): vec={vec[3:0], vec[4]^vec[2]}.
- Last vector:
  - mode 0: vec_idx==31, giving 32 vectors in order 00000..11111.
  - mode 1: vec_idx==30, giving 31 distinct non-zero states. An LFSR state of 0 is never produced.
- DONE: done=1, busy=0, vec_valid=0; the N pins hold the last vector. A start here restarts the run and clears done on the next cycle.
- start while busy is ignored; the latched mode is unaffected.
- abort in SETTLE or VALID: next state is IDLE; vec_valid, busy and done go to 0; the N pins hold their value.
- abort and handshake in the same cycle: abort wins, and the vector is treated as not consumed.
- abort in IDLE or DONE has no effect.
- ready is ignored outside VALID.
- mode changes after the accepted start have no effect until the next start.

Test Plan:
1. HOLD_CYCLES=2, mode=0, ready tied 1, pulse start → vector 00000 on the N pins at cycle t+1, first vec_valid at t+3, one vector per 3 cycles, 32 handshakes in the order 00000..11111, the 5th vector is {N7..N1}=00100, done=1 after vec_idx 31 is accepted.
2. mode=1, seed 00001, ready=1 → vector sequence 00001, 00010, 00100, 01001, 10010, …; 31 handshakes, all non-zero and distinct, the 32nd state would equal 00001; done after vec_idx 30.
3. Backpressure: hold ready=0 for 10 cycles with vec_valid=1 at vector 00111 → vec_valid, the N pins and vec_idx (=7) stay constant; ready=1 gives one handshake, and the next vector 01000 appears on the following cycle.
4. Pulse start while busy, then pulse abort during SETTLE of vec_idx 12 → the start has no effect; the next cycle shows IDLE, busy=0, vec_valid=0, N pins =01100; a fresh start begins again at 00000.
5. Assert rst in VALID at vec_idx 20 → next cycle all outputs are at reset values (N pins 0, idx 0, done 0). Also check rst asserted together with start in IDLE: the state stays IDLE.
6. HOLD_CYCLES=0, LFSR_SEED=0, mode=1, ready=1 → vec_valid on the cycle after start with vector 00001; one handshake per cycle; done after 31 cycles.
